prio_encoder_rr: RTL and testbench
==================================

Name: prio_encoder_rr

Overview:
- Parametrised, registered N-to-log2(N) priority encoder. Successor to the team's 4-to-2 combinational priority encoder.
- Adds width generalisation, valid/ready handshakes on both sides, and a selectable round-robin mode that prevents starvation.
- Used as the grant-index stage in front of shared resources: bus masters and interrupt lines.

Parameters:
- N, 8: number of request lines; legal range 2..64, power of two not required.
- W, $clog2(N): index width; derived, not to be overridden.
- MODE, 0: 0 = fixed priority (highest index wins); 1 = round-robin.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  N  request vector; sampled only on an input transfer.
- req_valid  in  1  req is presented.
- req_ready  out  1  block can accept req this cycle.
- idx  out  W  encoded winning index.
- none  out  1  accepted req was all-zero; idx is 0.
- idx_valid  out  1  idx/none hold a result.
- idx_ready  in  1  consumer takes the result this cycle.

Behaviour:
- Transfers:
  - Input transfer = req_valid & req_ready.
  - Output transfer = idx_valid & idx_ready.
- req_ready = !idx_valid | idx_ready. This is a combinational path from idx_ready and allows one result per cycle sustained.
- Latency: result appears in idx/idx_valid on the cycle after the input transfer. No combinational path from req to idx.
- Output register, evaluated each edge:
  - If input transfer: load idx/none and set idx_valid=1.
  - Else if output transfer: clear idx_valid.
  - Else: hold.
  - idx and none are stable while idx_valid=1 and idx_ready=0.
- Fixed mode (MODE=0): idx = highest set bit of req. Example: N=4, req=0110 gives idx=2.
- Round-robin mode (MODE=1):
  - Internal pointer ptr[W-1:0], reset value N-1.
  - Scan starts at ptr and descends, wrapping from 0 to N-1. The first set bit wins.
  - After a winning grant g, ptr becomes g-1, or N-1 when g=0 (wrap). Bit g becomes lowest priority.
  - ptr updates only on an input transfer with a nonzero req.
  - With ptr at its reset value, the first grant matches fixed mode.
- Zero request: idx=0, none=1, idx_valid=1 (a result is still produced). ptr is unchanged.
- Single set bit: that index wins in both modes, regardless of ptr.
- Simultaneous input and output transfer in the same cycle: the new result replaces the old one, and idx_valid stays 1.
- Reset values: idx_valid=0, idx=0, none=0, ptr=N-1. req_ready reads 1 during and after reset.
- Reset mid-operation: any held result is discarded and ptr is restored. An input presented in the reset cycle is not accepted.
- N not a power of two: ptr wraps to N-1, never to 2^W-1. idx is never >= N.

Decomposition:
- Package prio_enc_pkg:
  - MODE_FIXED=0, MODE_RR=1.
  - Function clog2_min1, which returns at least 1 so that N=2 still gives W=1.
- One sub-module, prio_scan:
  - Combinational; parameters N, W.
  - Inputs: req, start index.
  - Outputs: first set index at or below start, wrapping; and an any flag.
- Fixed mode instantiates prio_scan with start tied to N-1. RR mode drives start from ptr.
- Top level holds the handshake register and ptr.

Test Plan (N=8 unless stated):
- MODE=0, idx_ready=1: req=0010_1100 -> next cycle idx=5, none=0, idx_valid=1. Then req=0000_0001 -> idx=0.
- MODE=1, three back-to-back requests req=FF -> idx=7, 6, 5 on consecutive cycles. req_ready stays 1 throughout.
- MODE=1 wrap:
  - req=0000_0001 -> idx=0 and ptr becomes 7.
  - req=1000_0001 -> idx=7.
  - req=1000_0001 -> idx=0.
- Zero request in MODE=1 after a grant of 3 -> idx=0, none=1. The following req=FF -> idx=2, confirming ptr was unchanged.
- Backpressure:
  - Hold idx_ready=0 for 4 cycles with req_valid=1 -> req_ready=0, and idx/none stay frozen.
  - Raise idx_ready -> old result transfers, and the pending req is accepted in the same cycle.
- Reset mid-stream: assert rst while idx_valid=1 and ptr=3 -> next cycle idx_valid=0, none=0. The next req=FF (MODE=1) -> idx=7.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the registered priority encoder and its scan stage.
package prio_enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Index width that never collapses to zero, so N=2 still gets a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_scan.sv
// Combinational circular scan: first set request at or below start, descending and wrapping to N-1.
module prio_scan
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] first,
    output logic         any
);

    logic [W-1:0] pos;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        first = '0;
        any   = 1'b0;
        pos   = start;
        for (int i = 0; i < N; i++) begin
            if (!any && req[pos]) begin
                first = pos;
                any   = 1'b1;
            end
            // Wrap to the last real line, not to 2^W-1, so non-power-of-two N stays in range.
            pos = (pos == '0) ? W'(N - 1) : pos - W'(1);
        end
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with valid/ready on both sides and optional round-robin.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int MODE = MODE_FIXED,
    localparam int W    = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         req_valid,
    output logic         req_ready,
    output logic [W-1:0] idx,
    output logic         none,
    output logic         idx_valid,
    input  logic         idx_ready
);

    logic [W-1:0] ptr;
    logic [W-1:0] scan_start;
    logic [W-1:0] grant;
    logic         grant_any;
    logic         in_xfer;

    // Ready while reset is held too; the register ignores the input in that cycle anyway.
    assign req_ready  = rst | ~idx_valid | idx_ready;
    assign in_xfer    = req_valid & req_ready;
    assign scan_start = (MODE == MODE_RR) ? ptr : W'(N - 1);

    prio_scan #(
        .N (N),
        .W (W)
    ) u_scan (
        .req   (req),
        .start (scan_start),
        .first (grant),
        .any   (grant_any)
    );

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_valid <= 1'b0;
            idx       <= '0;
            none      <= 1'b0;
            ptr       <= W'(N - 1);
        end else if (in_xfer) begin
            idx       <= grant;
            none      <= ~grant_any;
            idx_valid <= 1'b1;
            // The winner drops to lowest priority; an all-zero request leaves the pointer alone.
            if (MODE == MODE_RR && grant_any)
                ptr <= (grant == '0) ? W'(N - 1) : grant - W'(1);
        end else if (idx_valid && idx_ready) begin
            idx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench: fixed N=8, round-robin N=8 and round-robin N=5 instances sharing one stimulus stream.
module tb_prio_encoder_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req8;
    logic       req_valid;
    logic       idx_ready;

    logic [2:0] idx_fix, idx_rr, idx_r5;
    logic       none_fix, none_rr, none_r5;
    logic       val_fix, val_rr, val_r5;
    logic       rdy_fix, rdy_rr, rdy_r5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prio_encoder_rr #(.N(8), .MODE(0)) u_fix (
        .clk(clk), .rst(rst), .req(req8), .req_valid(req_valid), .req_ready(rdy_fix),
        .idx(idx_fix), .none(none_fix), .idx_valid(val_fix), .idx_ready(idx_ready)
    );

    prio_encoder_rr #(.N(8), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .req(req8), .req_valid(req_valid), .req_ready(rdy_rr),
        .idx(idx_rr), .none(none_rr), .idx_valid(val_rr), .idx_ready(idx_ready)
    );

    prio_encoder_rr #(.N(5), .MODE(1)) u_r5 (
        .clk(clk), .rst(rst), .req(req8[4:0]), .req_valid(req_valid), .req_ready(rdy_r5),
        .idx(idx_r5), .none(none_r5), .idx_valid(val_r5), .idx_ready(idx_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] r, input logic v, input logic rdy);
        req8      = r;
        req_valid = v;
        idx_ready = rdy;
    endtask

    task automatic expect_res(input string tag, input int fi, input int ri, input int r5i,
                              input logic nn);
        check({tag, "/fix_idx"},  64'(idx_fix),  64'(fi));
        check({tag, "/rr_idx"},   64'(idx_rr),   64'(ri));
        check({tag, "/r5_idx"},   64'(idx_r5),   64'(r5i));
        check({tag, "/fix_none"}, 64'(none_fix), 64'(nn));
        check({tag, "/rr_none"},  64'(none_rr),  64'(nn));
        check({tag, "/r5_none"},  64'(none_r5),  64'(nn));
        check({tag, "/fix_val"},  64'(val_fix),  64'(1));
        check({tag, "/rr_val"},   64'(val_rr),   64'(1));
        check({tag, "/r5_val"},   64'(val_r5),   64'(1));
    endtask

    task automatic expect_ready(input string tag, input logic exp);
        check({tag, "/fix_rdy"}, 64'(rdy_fix), 64'(exp));
        check({tag, "/rr_rdy"},  64'(rdy_rr),  64'(exp));
        check({tag, "/r5_rdy"},  64'(rdy_r5),  64'(exp));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "/fix_val"},  64'(val_fix),  64'(0));
        check({tag, "/rr_val"},   64'(val_rr),   64'(0));
        check({tag, "/r5_val"},   64'(val_r5),   64'(0));
        check({tag, "/rr_none"},  64'(none_rr),  64'(0));
        check({tag, "/rr_idx"},   64'(idx_rr),   64'(0));
    endtask

    initial begin
        rst = 1'b1;
        drive(8'h00, 1'b0, 1'b1);
        #1;
        expect_ready("rst_ready", 1'b1);
        tick();
        tick();
        expect_idle("reset");
        check("reset/fix_none", 64'(none_fix), 64'(0));
        check("reset/fix_idx",  64'(idx_fix),  64'(0));
        expect_ready("post_rst_ready", 1'b1);
        rst = 1'b0;

        // Basic grants: rr pointers start at N-1 so first grant matches fixed mode for N=8.
        drive(8'b0010_1100, 1'b1, 1'b1); tick(); expect_res("req2C", 5, 5, 3, 1'b0);
        drive(8'b0000_0001, 1'b1, 1'b1); tick(); expect_res("req01", 0, 0, 0, 1'b0);

        // Back-to-back all-ones: rotating grants, sustained throughput.
        drive(8'hFF, 1'b1, 1'b1); tick(); expect_res("ff_1", 7, 7, 4, 1'b0); expect_ready("ff_1", 1'b1);
        tick(); expect_res("ff_2", 7, 6, 3, 1'b0); expect_ready("ff_2", 1'b1);
        tick(); expect_res("ff_3", 7, 5, 2, 1'b0); expect_ready("ff_3", 1'b1);

        // Wrap at index 0.
        drive(8'b0000_0001, 1'b1, 1'b1); tick(); expect_res("wrap_01", 0, 0, 0, 1'b0);
        drive(8'b1000_0001, 1'b1, 1'b1); tick(); expect_res("wrap_81a", 7, 7, 0, 1'b0);
        tick(); expect_res("wrap_81b", 7, 0, 0, 1'b0);

        // Zero request leaves the pointer where the grant of 3 put it.
        drive(8'b0000_1000, 1'b1, 1'b1); tick(); expect_res("g3", 3, 3, 3, 1'b0);
        drive(8'h00, 1'b1, 1'b1);        tick(); expect_res("zero", 0, 0, 0, 1'b1);
        drive(8'hFF, 1'b1, 1'b1);        tick(); expect_res("after_zero", 7, 2, 2, 1'b0);

        // N=5 instance must wrap its pointer to 4, not 7.
        drive(8'b0000_0001, 1'b1, 1'b1); tick(); expect_res("n5_wrap", 0, 0, 0, 1'b0);
        drive(8'b0001_0001, 1'b1, 1'b1); tick(); expect_res("n5_top", 4, 4, 4, 1'b0);

        // Backpressure: result frozen, input stalled.
        drive(8'hFF, 1'b1, 1'b0);
        #1;
        expect_ready("bp_enter", 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            expect_res($sformatf("bp_hold%0d", c), 4, 4, 4, 1'b0);
            expect_ready($sformatf("bp_hold%0d", c), 1'b0);
        end
        idx_ready = 1'b1;
        #1;
        expect_ready("bp_release", 1'b1);
        tick(); expect_res("bp_accept", 7, 3, 3, 1'b0);

        // Bring both rr pointers to 3 with a result held, then reset mid-stream.
        drive(8'b0001_0000, 1'b1, 1'b1); tick(); expect_res("pre_rst", 4, 4, 4, 1'b0);
        rst = 1'b1;
        drive(8'hFF, 1'b1, 1'b0);
        #1;
        expect_ready("mid_rst_ready", 1'b1);
        tick();
        expect_idle("mid_rst");
        rst = 1'b0;
        drive(8'hFF, 1'b1, 1'b1); tick(); expect_res("post_rst_ff", 7, 7, 4, 1'b0);

        // Output-only transfer drains the register.
        drive(8'h00, 1'b0, 1'b1); tick();
        check("drain/fix_val", 64'(val_fix), 64'(0));
        check("drain/rr_val",  64'(val_rr),  64'(0));
        check("drain/r5_val",  64'(val_r5),  64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
